// File: rtl/router_pkg.sv
// Shared types and constants for the router packet generator.
// Holds widths, FSM state encoding and port address values.
package router_pkg;

  localparam int DW     = 3;
  localparam int MAXLEN = 7;
  localparam int CW     = 3;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HDR,
    LENW,
    PAYLOAD,
    PARITY
  } state_t;

  localparam logic [1:0] ADDR_P0  = 2'd0;
  localparam logic [1:0] ADDR_P1  = 2'd1;
  localparam logic [1:0] ADDR_P2  = 2'd2;
  localparam logic [1:0] ADDR_INV = 2'd3;

endpackage

// File: rtl/router_pkt_buf.sv
// Payload register file: DEPTH x DW, sync write, async read.
// Ports: clock/resetn, wr_en/wr_addr/wr_data, rd_addr/rd_data.
module router_pkt_buf #(
  parameter int DW    = 3,
  parameter int DEPTH = 7,
  parameter int AW    = 3
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Address DEPTH is reached one past the last word; read 0 there.
  assign rd_data = (32'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;

endmodule

// File: rtl/router_pkt_gen.sv
// Builds header/length/payload/parity packets for the router.
// Ports: clock, resetn, start/dest/len, pl_* load, busy,
// data_in/pkt_valid stream, done, cfg_err pulses.
// Option: PKT_GEN_PARITY_CORRUPT_EN adds input corrupt.
module router_pkt_gen #(
  parameter int DW     = router_pkg::DW,
  parameter int MAXLEN = router_pkg::MAXLEN
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic [1:0]    dest,
  input  logic [2:0]    len,
  input  logic [DW-1:0] pl_data,
  input  logic          pl_valid,
  output logic          pl_ready,
  input  logic          busy,
  output logic [DW-1:0] data_in,
  output logic          pkt_valid,
  output logic          done,
  output logic          cfg_err
`ifdef PKT_GEN_PARITY_CORRUPT_EN
  ,
  input  logic          corrupt
`endif
);

  import router_pkg::*;

  state_t        state;
  logic [1:0]    dest_q;
  logic [2:0]    len_q;
  logic [2:0]    cnt;
  logic [DW-1:0] par;
  logic [DW-1:0] par_out;
  logic [DW-1:0] rd_data;
  logic          start_ok;
  logic          wr_en;
  logic          xfer;

  assign start_ok = (dest != ADDR_INV) &&
                    (len != 3'd0) &&
                    ({1'b0, len} <= 4'(MAXLEN));
  assign wr_en    = (state == LOAD) && pl_valid;
  assign xfer     = !busy;

`ifdef PKT_GEN_PARITY_CORRUPT_EN
  logic corrupt_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      corrupt_q <= 1'b0;
    end else if (state == IDLE && start) begin
      corrupt_q <= corrupt;
    end
  end

  // Error injection flips only bit0 of the parity word.
  assign par_out = par ^ DW'(corrupt_q);
`else
  assign par_out = par;
`endif

  router_pkt_buf #(
    .DW    (DW),
    .DEPTH (MAXLEN),
    .AW    (CW)
  ) u_buf (
    .clock   (clock),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .wr_addr (cnt),
    .wr_data (pl_data),
    .rd_addr (cnt),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      dest_q    <= '0;
      len_q     <= '0;
      cnt       <= '0;
      par       <= '0;
      data_in   <= '0;
      pkt_valid <= 1'b0;
      pl_ready  <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              state    <= LOAD;
              pl_ready <= 1'b1;
              dest_q   <= dest;
              len_q    <= len;
              cnt      <= '0;
              // Seed parity with header and length words.
              par      <= DW'(dest) ^ DW'(len);
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (pl_valid) begin
            par <= par ^ pl_data;
            if (cnt == len_q - 3'd1) begin
              state     <= HDR;
              pl_ready  <= 1'b0;
              cnt       <= '0;
              data_in   <= DW'(dest_q);
              pkt_valid <= 1'b1;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        HDR: begin
          if (xfer) begin
            state   <= LENW;
            data_in <= DW'(len_q);
          end
        end
        LENW: begin
          if (xfer) begin
            state   <= PAYLOAD;
            data_in <= rd_data;
            cnt     <= cnt + 3'd1;
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            // cnt counts payload words already presented.
            if (cnt == len_q) begin
              state     <= PARITY;
              data_in   <= par_out;
              pkt_valid <= 1'b0;
            end else begin
              data_in <= rd_data;
              cnt     <= cnt + 3'd1;
            end
          end
        end
        PARITY: begin
          if (xfer) begin
            state   <= IDLE;
            data_in <= '0;
            done    <= 1'b1;
            cnt     <= '0;
            par     <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_gen.sv
// Self-checking bench for router_pkt_gen.
// Table of packets plus cfg_err and reset sequences.
module tb_router_pkt_gen;

  logic       clock;
  logic       resetn;
  logic       start;
  logic [1:0] dest;
  logic [2:0] len;
  logic [2:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       busy;
  logic [2:0] data_in;
  logic       pkt_valid;
  logic       done;
  logic       cfg_err;
`ifdef PKT_GEN_PARITY_CORRUPT_EN
  logic       corrupt;
`endif

  int n_cmp;
  int n_bad;
  int cyc;

  typedef struct packed {
    logic [1:0]      dest;
    logic [2:0]      len;
    logic [6:0][2:0] pl;
    logic [2:0]      par;
    logic            crpt;
    int              busy_at;
    int              busy_n;
    bit              tog;
  } vec_t;

  vec_t tbl[$];

  router_pkt_gen dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .dest      (dest),
    .len       (len),
    .pl_data   (pl_data),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .busy      (busy),
    .data_in   (data_in),
    .pkt_valid (pkt_valid),
    .done      (done),
    .cfg_err   (cfg_err)
`ifdef PKT_GEN_PARITY_CORRUPT_EN
    ,
    .corrupt   (corrupt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(
    input logic [1:0] d, input logic [2:0] l,
    input logic [20:0] p, input logic [2:0] par,
    input logic cr, input int ba, input int bn,
    input bit tg);
    vec_t v;
    v.dest    = d;
    v.len     = l;
    v.pl      = p;
    v.par     = par;
    v.crpt    = cr;
    v.busy_at = ba;
    v.busy_n  = bn;
    v.tog     = tg;
    return v;
  endfunction

  task automatic run_pkt(input vec_t v, input int idx);
    int  n, bc, k, rdy, g, t0, ew, lat;
    bit  err_seen, vld;
    string p;
    p = $sformatf("v%0d", idx);
`ifdef PKT_GEN_PARITY_CORRUPT_EN
    corrupt = v.crpt;
`endif
    start = 1'b1;
    dest  = v.dest;
    len   = v.len;
    t0    = cyc;
    @(negedge clock);
    start    = 1'b0;
    err_seen = 1'b0;
    rdy = 0;
    k   = 0;
    g   = 0;
    while (k < int'(v.len) && g < 64) begin
      if (pl_ready) rdy++;
      err_seen |= cfg_err;
      vld      = v.tog ? g[0] : 1'b1;
      pl_valid = vld;
      pl_data  = v.pl[k];
      start    = 1'b1;
      dest     = 2'd3;
      @(negedge clock);
      if (vld) k++;
      g++;
    end
    start    = 1'b0;
    pl_valid = 1'b0;
    chk({p, "_ld_words"}, k, int'(v.len));
    chk({p, "_rdy_cyc"}, rdy,
        v.tog ? 2 * int'(v.len) : int'(v.len));
    chk({p, "_rdy_low"}, int'(pl_ready), 0);
    n  = 0;
    bc = 0;
    g  = 0;
    while (n < int'(v.len) + 3 && g < 64) begin
      if (n == 0) ew = int'(v.dest);
      else if (n == 1) ew = int'(v.len);
      else if (n < int'(v.len) + 2) ew = int'(v.pl[n-2]);
      else ew = int'(v.par);
      chk($sformatf("%s_w%0d_data", p, n),
          int'(data_in), ew);
      chk($sformatf("%s_w%0d_vld", p, n),
          int'(pkt_valid), (n < int'(v.len) + 2) ? 1 : 0);
      err_seen |= cfg_err;
      if (n == v.busy_at && bc < v.busy_n) begin
        busy = 1'b1;
        bc++;
      end else begin
        busy = 1'b0;
        n++;
      end
      @(negedge clock);
      g++;
    end
    busy = 1'b0;
    chk({p, "_words"}, n, int'(v.len) + 3);
    chk({p, "_done_hi"}, int'(done), 1);
    chk({p, "_cfg_err"}, int'(err_seen), 0);
    lat = 2 * int'(v.len) + 4 + v.busy_n +
          (v.tog ? int'(v.len) : 0);
    chk({p, "_latency"}, cyc - t0, lat);
    chk({p, "_idle_data"}, int'(data_in), 0);
    chk({p, "_idle_vld"}, int'(pkt_valid), 0);
    @(negedge clock);
    chk({p, "_done_lo"}, int'(done), 0);
  endtask

  initial begin
    bit seen;
    n_cmp    = 0;
    n_bad    = 0;
    cyc      = 0;
    resetn   = 1'b0;
    start    = 1'b0;
    dest     = '0;
    len      = '0;
    pl_data  = '0;
    pl_valid = 1'b0;
    busy     = 1'b0;
`ifdef PKT_GEN_PARITY_CORRUPT_EN
    corrupt  = 1'b0;
`endif

    // Parity column is XOR of header, length and payload.
    tbl.push_back(mkv(2'd1, 3'd2, 21'o35, 3'd5,
                      1'b0, -1, 0, 1'b0));
    tbl.push_back(mkv(2'd1, 3'd2, 21'o35, 3'd5,
                      1'b0, 3, 3, 1'b0));
    tbl.push_back(mkv(2'd2, 3'd7, 21'o7654321, 3'd5,
                      1'b0, -1, 0, 1'b1));
    tbl.push_back(mkv(2'd0, 3'd1, 21'o6, 3'd7,
                      1'b0, -1, 0, 1'b0));
    tbl.push_back(mkv(2'd2, 3'd3, 21'o407, 3'd2,
                      1'b0, 0, 2, 1'b0));
    tbl.push_back(mkv(2'd0, 3'd1, 21'o3, 3'd2,
                      1'b0, 3, 2, 1'b0));
`ifdef PKT_GEN_PARITY_CORRUPT_EN
    tbl.push_back(mkv(2'd0, 3'd1, 21'o6, 3'd6,
                      1'b1, -1, 0, 1'b0));
`endif

    #12;
    chk("rst_data", int'(data_in), 0);
    chk("rst_vld", int'(pkt_valid), 0);
    chk("rst_rdy", int'(pl_ready), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(cfg_err), 0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    foreach (tbl[i]) begin
      run_pkt(tbl[i], i);
    end

    // Rejected starts: bad destination, then zero length.
    for (int t = 0; t < 2; t++) begin
      start = 1'b1;
      dest  = (t == 0) ? 2'd3 : 2'd1;
      len   = (t == 0) ? 3'd2 : 3'd0;
      @(negedge clock);
      start = 1'b0;
      chk($sformatf("cfg%0d_err_hi", t), int'(cfg_err), 1);
      chk($sformatf("cfg%0d_rdy", t), int'(pl_ready), 0);
      chk($sformatf("cfg%0d_vld", t), int'(pkt_valid), 0);
      chk($sformatf("cfg%0d_data", t), int'(data_in), 0);
      @(negedge clock);
      chk($sformatf("cfg%0d_err_lo", t), int'(cfg_err), 0);
      chk($sformatf("cfg%0d_rdy2", t), int'(pl_ready), 0);
    end

    // Reset while streaming the second payload word.
    start = 1'b1;
    dest  = 2'd2;
    len   = 3'd4;
    @(negedge clock);
    start = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      pl_valid = 1'b1;
      pl_data  = 3'(w);
      @(negedge clock);
    end
    pl_valid = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_mid_data", int'(data_in), 2);
    chk("rst_mid_vld", int'(pkt_valid), 1);
    @(posedge clock);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_data", int'(data_in), 0);
    chk("arst_vld", int'(pkt_valid), 0);
    chk("arst_rdy", int'(pl_ready), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_err", int'(cfg_err), 0);
    @(negedge clock);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      seen |= done | pkt_valid | pl_ready;
    end
    chk("post_rst_quiet", int'(seen), 0);
    run_pkt(mkv(2'd2, 3'd4, 21'o4321, 3'd2,
                1'b0, -1, 0, 1'b0), 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
